// File: rtl/des_sbox_hash_stream_if.sv
// Byte-stream input and digest output handshake bundle for the DES S-box hash core.
interface des_sbox_hash_stream_if;
   logic        msg_valid;
   logic        msg_ready;
   logic [7:0]  msg_data;
   logic        msg_last;
   logic        digest_valid;
   logic        digest_ready;
   logic [31:0] digest;

   modport master (
      output msg_valid, msg_data, msg_last, digest_ready,
      input  msg_ready, digest_valid, digest
   );

   modport slave (
      input  msg_valid, msg_data, msg_last, digest_ready,
      output msg_ready, digest_valid, digest
   );
endinterface

// File: rtl/des_sbox_hash_stream.sv
// Iterative DES-S5 based 32-bit hash: one compression round per clock, length-keyed
// final transformation, digest held on a valid/ready output until consumed.
module des_sbox_hash_stream #(
   parameter int unsigned ROUNDS = 4,
   parameter int unsigned LEN_W  = 64,
   parameter logic [31:0] IV     = 32'h4B71DF03
) (
   input  logic                  clk,
   input  logic                  rst_n,
   des_sbox_hash_stream_if.slave bus,
   output logic [LEN_W-1:0]      byte_count,
   output logic                  busy
);

   // S5 rows, column 0 in the top nibble
   localparam logic [63:0] S5_R0 = 64'h2C417AB6853FD0E9;
   localparam logic [63:0] S5_R1 = 64'hEB2C47D150FA3986;
   localparam logic [63:0] S5_R2 = 64'h421BAD78F9C5630E;
   localparam logic [63:0] S5_R3 = 64'hB8C71E2D6F09A453;
   localparam logic [3:0]  RND_LAST = 4'(ROUNDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_ROUND, S_FINAL, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_h;
   logic [3:0]        r_s;
   logic              r_last;
   logic [3:0]        r_rnd;
   logic [LEN_W-1:0]  r_cnt;
   logic [31:0]       r_digest;
   logic              r_dvalid;
   logic              w_ready;
   logic              w_hs;
   logic [63:0]       w_len;
   logic [31:0]       w_fkey;

   function automatic logic [5:0] f_m6(input logic [7:0] m);
      return {m[3] ^ m[2], m[1], m[0], m[7], m[6], m[5] ^ m[4]};
   endfunction

   function automatic logic [5:0] f_c6(input logic [7:0] c);
      return {c[7] ^ c[1], c[3], c[2], c[5] ^ c[0], c[4], c[6]};
   endfunction

   function automatic logic [3:0] f_sbox(input logic [5:0] x);
      logic [63:0] row;
      case ({x[5], x[0]})
         2'd0:    row = S5_R0;
         2'd1:    row = S5_R1;
         2'd2:    row = S5_R2;
         default: row = S5_R3;
      endcase
      // inverting the column turns "column 0 = top nibble" into an ascending bit offset
      return row[{~x[4:1], 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] f_rotl4(input logic [3:0] v, input logic [1:0] amt);
      logic [7:0] w;
      w = {v, v} << amt;
      return w[7:4];
   endfunction

   // One mixing step; k carries the per-nibble S-box value (all equal during rounds)
   function automatic logic [31:0] f_mix(input logic [31:0] h, input logic [31:0] k);
      logic [31:0] o;
      o = '0;
      for (int i = 0; i < 8; i++) begin
         o[31-4*i -: 4] = f_rotl4(h[31-4*((i+1)%8) -: 4] ^ k[31-4*i -: 4], 2'(i/2));
      end
      return o;
   endfunction

   assign w_ready    = (r_state == S_IDLE) || (r_state == S_ACCEPT);
   assign w_hs       = bus.msg_valid & w_ready;
   assign w_len      = 64'(r_cnt);

   assign bus.msg_ready    = w_ready;
   assign bus.digest_valid = r_dvalid;
   assign bus.digest       = r_digest;
   assign byte_count       = r_cnt;
   assign busy             = (r_state != S_IDLE);

   always_comb begin
      w_fkey = '0;
      for (int i = 0; i < 8; i++) begin
         w_fkey[31-4*i -: 4] = f_sbox(f_c6(w_len[63-8*i -: 8]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_ACCEPT: if (w_hs) w_state_nxt = S_ROUND;
         S_ROUND: begin
            if (r_rnd == RND_LAST) w_state_nxt = r_last ? S_FINAL : S_ACCEPT;
         end
         S_FINAL: w_state_nxt = S_DONE;
         S_DONE:  if (bus.digest_ready) w_state_nxt = S_ACCEPT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h      <= IV;
         r_s      <= '0;
         r_last   <= 1'b0;
         r_rnd    <= '0;
         r_cnt    <= '0;
         r_digest <= '0;
         r_dvalid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_ACCEPT: begin
               if (w_hs) begin
                  r_s    <= f_sbox(f_m6(bus.msg_data));
                  r_last <= bus.msg_last;
                  r_cnt  <= r_cnt + 1'b1;
                  r_rnd  <= '0;
               end
            end
            S_ROUND: begin
               r_h   <= f_mix(r_h, {8{r_s}});
               r_rnd <= r_rnd + 4'd1;
            end
            S_FINAL: begin
               r_digest <= f_mix(r_h, w_fkey);
               r_dvalid <= 1'b1;
            end
            S_DONE: begin
               if (bus.digest_ready) begin
                  r_dvalid <= 1'b0;
                  r_h      <= IV;
                  r_cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/des_sbox_hash_stream.md
Name: des_sbox_hash_stream

Overview:
- Parametrised successor of the DES S-box 32-bit hash core.
- Accepts message bytes over a valid/ready stream with a last-byte flag, counts message length internally and runs the compression rounds iteratively, one round per clock.
- Applies the length-dependent final transformation and holds the 32-bit digest on a valid/ready output until it is taken.
- Sits between the byte-stream front end and the digest consumer.

Parameters:
- ROUNDS, 4, compression rounds per message byte; legal range 1..15.
- LEN_W, 64, width of the internal byte counter; legal range 8..64. The counter is zero-extended to 64 bits for the final step.
- IV, 32'h4B71DF03, initial hash value. H[0] is IV[31:28] and H[7] is IV[3:0].

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- msg_valid  in  1  msg_data is valid this cycle.
- msg_ready  out  1  block accepts a byte this cycle.
- msg_data  in  8  message byte.
- msg_last  in  1  qualifies msg_data as the final byte of the message.
- digest_valid  out  1  digest holds a completed result.
- digest_ready  in  1  consumer takes the digest.
- digest  out  32  hash result, H[0] in bits [31:28].
- byte_count  out  LEN_W  bytes accepted so far in the current message.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-round and while digest_valid is high):
  - state=IDLE, H=IV, byte_count=0.
  - msg_ready=1, digest_valid=0, digest=0, busy=0.
  - Any partially hashed message is discarded.
- Primitives:
  - M6 = {m3^m2, m1, m0, m7, m6, m5^m4}.
  - C6 = {c7^c1, c3, c2, c5^c0, c4, c6}.
  - S(x): DES S5 table. Row = {x[5], x[0]}, column = x[4:1].
  - Row 0 = 2,C,4,1,7,A,B,6,8,5,3,F,D,0,E,9.
  - Rows 1-3 are the same S5 rows as in the existing core.
  - Round(H, s): H'[i] = rotl4(H[(i+1) mod 8] ^ s, floor(i/2)) for i=0..7.
- State IDLE/ACCEPT: msg_ready=1. A handshake (msg_valid & msg_ready) does all of the following:
  - Latches s=S(M6(msg_data)) and msg_last.
  - byte_count <= byte_count+1, wrapping mod 2^LEN_W.
  - Sets rnd=0 and moves to ROUND.
- State ROUND:
  - msg_ready=0.
  - Each cycle: H <= Round(H, s), rnd <= rnd+1.
  - After ROUNDS cycles, go to FINAL if the latched last flag is set, otherwise back to ACCEPT.
  - Byte-to-byte throughput is ROUNDS+1 cycles per byte.
- State FINAL, one cycle:
  - Let L = zero-extended byte_count (64 bit).
  - C byte i = L[63-8i -: 8], i=0..7.
  - H'[i] = rotl4(H[(i+1) mod 8] ^ S(C6(byte i)), floor(i/2)).
  - digest <= {H'[0..7]}, digest_valid <= 1, go to DONE.
- State DONE:
  - msg_ready=0.
  - digest, digest_valid and byte_count are held stable while digest_ready=0.
  - On digest_ready: digest_valid <= 0, H <= IV, byte_count <= 0, go to ACCEPT.
  - digest retains its last value after the handshake.
- Latency: last-byte handshake at cycle t gives digest_valid=1 at cycle t+ROUNDS+2.
- Boundary cases:
  - msg_valid while msg_ready=0: ignored. The producer must hold the byte stable until accepted.
  - msg_last without msg_valid: no effect.
  - Zero-length messages are not supported; every message carries at least one byte.
  - byte_count wrap to 0 on overflow is legal; the final step uses the wrapped value.
  - digest_ready while digest_valid=0: no effect.

Test Plan:
- Reset mid-message: assert rst_n=0 during ROUND, then release. Required: msg_ready=1, byte_count=0, digest_valid=0. A following message hashes identically to one sent after a clean reset.
- ROUNDS=1, single byte 0x00 with msg_last. Required: H after the round = 0x956F7883, digest=0x74BAAA8E, digest_valid at handshake cycle +3, byte_count=1.
- Default ROUNDS=4, single byte 0x00 with msg_last. Required: H after rounds = 0xB3602742, digest=0x1440590F, digest_valid at handshake cycle +6.
- Backpressure:
  - Hold digest_ready=0 for 20 cycles. Required: digest stable, digest_valid=1, msg_ready=0 throughout.
  - Then pulse digest_ready for one cycle. Required: digest_valid=0 and msg_ready=1 on the next cycle.
- Multi-byte, back-to-back: send "abc" with msg_valid held high. Required: msg_ready high exactly once every 5 cycles, and the digest matches the bit-accurate reference model with byte_count=3.
- LEN_W=8 wrap: stream 257 bytes of 0x00. Required: byte_count=1 at the end, and the digest equals the model result using L=1.
